// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: ALU and branch encodings, default widths,
// and the packed control bundle that travels from ID into EX.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;

  localparam logic [1:0] BR_JMP = 2'b00;
  localparam logic [1:0] BR_BEZ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       is_imm;
    logic [1:0] branch_type;
  } ctrl_t;

  // A bubble has no side effects: no memory access, no write-back.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle.
//   master : upstream side (drives ID fields, freeze/flush, MEM write-back info)
//   slave  : the ID/EX stage register (drives EX fields, hazard_stall, stall_cnt)
interface id_ex_stage_reg_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CNT_W  = 16
);
  logic              freeze;
  logic              flush;
  logic              id_valid;
  logic [3:0]        id_alu_cmd;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_wb_en;
  logic              id_is_imm;
  logic [1:0]        id_branch_type;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_val1;
  logic [DATA_W-1:0] id_val2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic [REG_AW-1:0] id_dest;
  logic              mem_wb_en;
  logic [REG_AW-1:0] mem_dest;

  logic              ex_valid;
  logic [3:0]        ex_alu_cmd;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_wb_en;
  logic              ex_is_imm;
  logic [1:0]        ex_branch_type;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_val1;
  logic [DATA_W-1:0] ex_val2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_src1;
  logic [REG_AW-1:0] ex_src2;
  logic [REG_AW-1:0] ex_dest;
  logic              hazard_stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output freeze, flush, id_valid, id_alu_cmd, id_mem_read, id_mem_write,
           id_wb_en, id_is_imm, id_branch_type, id_pc, id_val1, id_val2,
           id_imm, id_src1, id_src2, id_dest, mem_wb_en, mem_dest,
    input  ex_valid, ex_alu_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
           ex_is_imm, ex_branch_type, ex_pc, ex_val1, ex_val2, ex_imm,
           ex_src1, ex_src2, ex_dest, hazard_stall, stall_cnt
  );

  modport slave (
    input  freeze, flush, id_valid, id_alu_cmd, id_mem_read, id_mem_write,
           id_wb_en, id_is_imm, id_branch_type, id_pc, id_val1, id_val2,
           id_imm, id_src1, id_src2, id_dest, mem_wb_en, mem_dest,
    output ex_valid, ex_alu_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
           ex_is_imm, ex_branch_type, ex_pc, ex_val1, ex_val2, ex_imm,
           ex_src1, ex_src2, ex_dest, hazard_stall, stall_cnt
  );

endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Combinational read-after-write hazard detector for the ID stage.
// Ports: ID source decode inputs (i_id_*), EX-stage destination/control
// (i_ex_*), MEM-stage write-back (i_mem_*); o_hazard_stall requests a bubble.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1,
  parameter int REG_AW     = cpu_pkg::REG_AW
) (
  input  logic              i_id_valid,
  input  logic              i_id_is_imm,
  input  logic              i_id_mem_read,
  input  logic [1:0]        i_id_branch_type,
  input  logic [REG_AW-1:0] i_id_src1,
  input  logic [REG_AW-1:0] i_id_src2,
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_wb_en,
  input  logic [REG_AW-1:0] i_ex_dest,
  input  logic              i_mem_wb_en,
  input  logic [REG_AW-1:0] i_mem_dest,
  output logic              o_hazard_stall
);

  // r0 is hardwired zero, so a write to it can never be observed.
  function automatic logic reg_match(input logic [REG_AW-1:0] s,
                                     input logic [REG_AW-1:0] d);
    return (s == d) && (d != '0);
  endfunction

  logic w_src1_used;
  logic w_src2_used;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_load_use;
  logic w_any_pending;

  // Loads and immediates take operand 2 from the immediate; BEZ only tests src1.
  // Jumps are treated as using src2, which can false-stall but is harmless.
  assign w_src1_used = i_id_valid;
  assign w_src2_used = i_id_valid & ~i_id_is_imm & ~i_id_mem_read &
                       (i_id_branch_type != BR_BEZ);

  assign w_ex_hit  = (w_src1_used & reg_match(i_id_src1, i_ex_dest)) |
                     (w_src2_used & reg_match(i_id_src2, i_ex_dest));
  assign w_mem_hit = (w_src1_used & reg_match(i_id_src1, i_mem_dest)) |
                     (w_src2_used & reg_match(i_id_src2, i_mem_dest));

  assign w_load_use    = i_ex_valid & i_ex_mem_read & i_ex_wb_en & w_ex_hit;
  assign w_any_pending = (i_ex_valid & i_ex_wb_en & w_ex_hit) |
                         (i_mem_wb_en & w_mem_hit);

  // With forwarding only a load result in EX arrives too late to bypass.
  assign o_hazard_stall = FORWARD_EN ? w_load_use : w_any_pending;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hazard stall, branch flush, memory freeze and
// a saturating stall-cycle counter.
// Ports: clk, rst (async active-high), bus (id_ex_stage_reg_if.slave) carrying
// ID inputs, MEM write-back info, EX outputs, hazard_stall and stall_cnt.
module id_ex_stage_reg
  import cpu_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1,
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_AW     = cpu_pkg::REG_AW,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_reg_if.slave  bus
);

  ctrl_t             w_id_ctrl;
  logic              w_hazard_stall;

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_val1;
  logic [DATA_W-1:0] r_val2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_src1;
  logic [REG_AW-1:0] r_src2;
  logic [REG_AW-1:0] r_dest;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_id_ctrl = '{alu_cmd:     bus.id_alu_cmd,
                       mem_read:    bus.id_mem_read,
                       mem_write:   bus.id_mem_write,
                       wb_en:       bus.id_wb_en,
                       is_imm:      bus.id_is_imm,
                       branch_type: bus.id_branch_type};

  hazard_detect #(
    .FORWARD_EN (FORWARD_EN),
    .REG_AW     (REG_AW)
  ) u_hazard (
    .i_id_valid       (bus.id_valid),
    .i_id_is_imm      (bus.id_is_imm),
    .i_id_mem_read    (bus.id_mem_read),
    .i_id_branch_type (bus.id_branch_type),
    .i_id_src1        (bus.id_src1),
    .i_id_src2        (bus.id_src2),
    .i_ex_valid       (r_valid),
    .i_ex_mem_read    (r_ctrl.mem_read),
    .i_ex_wb_en       (r_ctrl.wb_en),
    .i_ex_dest        (r_dest),
    .i_mem_wb_en      (bus.mem_wb_en),
    .i_mem_dest       (bus.mem_dest),
    .o_hazard_stall   (w_hazard_stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
      r_pc        <= '0;
      r_val1      <= '0;
      r_val2      <= '0;
      r_imm       <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dest      <= '0;
      r_stall_cnt <= '0;
    end else if (!bus.freeze) begin
      // A stall coinciding with a flush still counts as a lost cycle.
      if (w_hazard_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bus.flush || w_hazard_stall) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_BUBBLE;
        r_pc    <= '0;
        r_val1  <= '0;
        r_val2  <= '0;
        r_imm   <= '0;
        r_src1  <= '0;
        r_src2  <= '0;
        r_dest  <= '0;
      end else begin
        r_valid <= bus.id_valid;
        r_ctrl  <= w_id_ctrl;
        r_pc    <= bus.id_pc;
        r_val1  <= bus.id_val1;
        r_val2  <= bus.id_val2;
        r_imm   <= bus.id_imm;
        r_src1  <= bus.id_src1;
        r_src2  <= bus.id_src2;
        r_dest  <= bus.id_dest;
      end
    end
  end

  assign bus.ex_valid       = r_valid;
  assign bus.ex_alu_cmd     = r_ctrl.alu_cmd;
  assign bus.ex_mem_read    = r_ctrl.mem_read;
  assign bus.ex_mem_write   = r_ctrl.mem_write;
  assign bus.ex_wb_en       = r_ctrl.wb_en;
  assign bus.ex_is_imm      = r_ctrl.is_imm;
  assign bus.ex_branch_type = r_ctrl.branch_type;
  assign bus.ex_pc          = r_pc;
  assign bus.ex_val1        = r_val1;
  assign bus.ex_val2        = r_val2;
  assign bus.ex_imm         = r_imm;
  assign bus.ex_src1        = r_src1;
  assign bus.ex_src2        = r_src2;
  assign bus.ex_dest        = r_dest;
  assign bus.hazard_stall   = w_hazard_stall;
  assign bus.stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: two instances share one stimulus stream,
// dut_f with forwarding and a 4-bit counter, dut_n without forwarding.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        imm;
    logic [1:0]  br;
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] immv;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
  } ex_t;

  typedef struct {
    ex_t         f;
    ex_t         n;
    logic [3:0]  cf;
    logic [15:0] cn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic       mwb = 1'b0;
  logic [4:0] mdest = '0;
  ex_t        idv = '0;

  ex_t         mf = '0;
  ex_t         mn = '0;
  logic [3:0]  cf = '0;
  logic [15:0] cn = '0;
  exp_t        q[$];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.CNT_W(4)) ifa ();
  id_ex_stage_reg_if              ifb ();

  id_ex_stage_reg #(.FORWARD_EN(1'b1), .CNT_W(4)) dut_f (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  id_ex_stage_reg #(.FORWARD_EN(1'b0), .CNT_W(16)) dut_n (
    .clk (clk), .rst (rst), .bus (ifb.slave));

  assign ifa.freeze = freeze;           assign ifb.freeze = freeze;
  assign ifa.flush = flush;             assign ifb.flush = flush;
  assign ifa.id_valid = idv.valid;      assign ifb.id_valid = idv.valid;
  assign ifa.id_alu_cmd = idv.alu;      assign ifb.id_alu_cmd = idv.alu;
  assign ifa.id_mem_read = idv.mr;      assign ifb.id_mem_read = idv.mr;
  assign ifa.id_mem_write = idv.mw;     assign ifb.id_mem_write = idv.mw;
  assign ifa.id_wb_en = idv.wb;         assign ifb.id_wb_en = idv.wb;
  assign ifa.id_is_imm = idv.imm;       assign ifb.id_is_imm = idv.imm;
  assign ifa.id_branch_type = idv.br;   assign ifb.id_branch_type = idv.br;
  assign ifa.id_pc = idv.pc;            assign ifb.id_pc = idv.pc;
  assign ifa.id_val1 = idv.v1;          assign ifb.id_val1 = idv.v1;
  assign ifa.id_val2 = idv.v2;          assign ifb.id_val2 = idv.v2;
  assign ifa.id_imm = idv.immv;         assign ifb.id_imm = idv.immv;
  assign ifa.id_src1 = idv.s1;          assign ifb.id_src1 = idv.s1;
  assign ifa.id_src2 = idv.s2;          assign ifb.id_src2 = idv.s2;
  assign ifa.id_dest = idv.d;           assign ifb.id_dest = idv.d;
  assign ifa.mem_wb_en = mwb;           assign ifb.mem_wb_en = mwb;
  assign ifa.mem_dest = mdest;          assign ifb.mem_dest = mdest;

  function automatic ex_t obs_f();
    return ex_t'({ifa.ex_valid, ifa.ex_alu_cmd, ifa.ex_mem_read, ifa.ex_mem_write,
                  ifa.ex_wb_en, ifa.ex_is_imm, ifa.ex_branch_type, ifa.ex_pc,
                  ifa.ex_val1, ifa.ex_val2, ifa.ex_imm, ifa.ex_src1, ifa.ex_src2,
                  ifa.ex_dest});
  endfunction

  function automatic ex_t obs_n();
    return ex_t'({ifb.ex_valid, ifb.ex_alu_cmd, ifb.ex_mem_read, ifb.ex_mem_write,
                  ifb.ex_wb_en, ifb.ex_is_imm, ifb.ex_branch_type, ifb.ex_pc,
                  ifb.ex_val1, ifb.ex_val2, ifb.ex_imm, ifb.ex_src1, ifb.ex_src2,
                  ifb.ex_dest});
  endfunction

  function automatic ex_t mk(logic v, logic [3:0] alu, logic mr, logic mw,
                             logic wb, logic imm, logic [1:0] br,
                             logic [31:0] pc, logic [31:0] v1, logic [31:0] v2,
                             logic [31:0] iv, logic [4:0] s1, logic [4:0] s2,
                             logic [4:0] d);
    ex_t e;
    e = '{valid: v, alu: alu, mr: mr, mw: mw, wb: wb, imm: imm, br: br,
          pc: pc, v1: v1, v2: v2, immv: iv, s1: s1, s2: s2, d: d};
    return e;
  endfunction

  // Reference hazard rule, evaluated from the ID fields and the modelled EX state.
  function automatic logic model_hz(ex_t id, ex_t ex, bit fwd, logic mw_en,
                                    logic [4:0] md);
    logic u1, u2, ex_hit, mem_hit;
    u1 = id.valid;
    u2 = id.valid && !id.imm && !id.mr && (id.br != 2'b01);
    ex_hit  = (u1 && id.s1 == ex.d && ex.d != 0) || (u2 && id.s2 == ex.d && ex.d != 0);
    mem_hit = (u1 && id.s1 == md && md != 0) || (u2 && id.s2 == md && md != 0);
    if (fwd) return ex.valid && ex.mr && ex.wb && ex_hit;
    return (ex.valid && ex.wb && ex_hit) || (mw_en && mem_hit);
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive-side: check combinational hazard, push expected EX state.
  // Output-side: after the edge, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    logic hf, hn;
    #1;
    hf = model_hz(idv, mf, 1'b1, mwb, mdest);
    hn = model_hz(idv, mn, 1'b0, mwb, mdest);
    chk({tag, "/hz_f"}, 160'(ifa.hazard_stall), 160'(hf));
    chk({tag, "/hz_n"}, 160'(ifb.hazard_stall), 160'(hn));
    if (!freeze) begin
      if (hf && cf != 4'hF) cf = cf + 4'd1;
      if (hn && cn != 16'hFFFF) cn = cn + 16'd1;
      mf = (flush || hf) ? ex_t'(0) : idv;
      mn = (flush || hn) ? ex_t'(0) : idv;
    end
    e.f = mf; e.n = mn; e.cf = cf; e.cn = cn;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "/ex_f"},  160'(obs_f()),       160'(e.f));
    chk({tag, "/ex_n"},  160'(obs_n()),       160'(e.n));
    chk({tag, "/cnt_f"}, 160'(ifa.stall_cnt), 160'(e.cf));
    chk({tag, "/cnt_n"}, 160'(ifb.stall_cnt), 160'(e.cn));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst/ex_f", 160'(obs_f()), 160'(0));
    chk("rst/ex_n", 160'(obs_n()), 160'(0));
    chk("rst/cnt_f", 160'(ifa.stall_cnt), 160'(0));
    chk("rst/hz_f", 160'(ifa.hazard_stall), 160'(0));

    // load r5 then dependent add
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h104, 32'h11, 32'h22, 32'h8, 1, 2, 5);
    step("ld5");
    idv = mk(1, 4'b0000, 0, 0, 1, 0, 2'b00, 32'h108, 32'hA5A5_0001, 32'h5A5A_0002,
             32'h0000_0033, 5, 6, 8);
    step("load_use");
    chk("load_use/cnt_lit", 160'(ifa.stall_cnt), 160'(1));
    chk("load_use/bubble_lit", 160'(ifa.ex_valid), 160'(0));
    step("add_enters");
    chk("add_enters/val1_lit", 160'(ifa.ex_val1), 160'(32'hA5A5_0001));
    chk("add_enters/imm_lit", 160'(ifa.ex_imm), 160'(32'h33));

    // id_valid=0 with a matching source must not stall
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h10C, 32'h1, 32'h2, 32'h4, 1, 2, 5);
    step("ld5b");
    idv = mk(0, 4'b0010, 0, 0, 1, 0, 2'b10, 32'h110, 32'h3, 32'h4, 32'h5, 5, 5, 9);
    step("invalid_id");

    // r0 never hazards; immediate form ignores src2
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h114, 32'h6, 32'h7, 32'h8, 1, 2, 0);
    step("ld_r0");
    idv = mk(1, 4'b0000, 0, 0, 1, 0, 2'b00, 32'h118, 32'h9, 32'hA, 32'hB, 0, 0, 4);
    step("use_r0");
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h11C, 32'hC, 32'hD, 32'hE, 1, 2, 7);
    step("ld7");
    idv = mk(1, 4'b0000, 0, 0, 1, 1, 2'b00, 32'h120, 32'hF, 32'h10, 32'h12, 2, 7, 10);
    step("addi_src2");

    // MEM-stage hazard (matters without forwarding)
    idv = mk(1, 4'b0000, 0, 1, 0, 0, 2'b00, 32'h124, 32'h13, 32'h14, 32'h15, 4, 3, 0);
    mwb = 1'b1; mdest = 5'd3;
    step("mem_haz1");
    step("mem_haz2");
    mwb = 1'b0;
    step("mem_clear");

    // flush coinciding with stall, then flush under freeze
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h128, 32'h16, 32'h17, 32'h18, 1, 2, 9);
    step("ld9");
    idv = mk(1, 4'b0010, 0, 0, 1, 0, 2'b01, 32'h12C, 32'h19, 32'h1A, 32'h1B, 9, 0, 11);
    flush = 1'b1;
    step("flush_stall");
    flush = 1'b0;
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h130, 32'h1C, 32'h1D, 32'h1E, 1, 2, 12);
    step("ld12");
    idv = mk(1, 4'b0101, 0, 0, 1, 0, 2'b00, 32'h134, 32'h1F, 32'h20, 32'h21, 12, 3, 13);
    flush = 1'b1; freeze = 1'b1;
    step("flush_freeze");
    flush = 1'b0;

    // freeze holds everything while ID changes
    for (int i = 0; i < 4; i++) begin
      if (i == 3) freeze = 1'b0;
      idv = mk(1, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
               $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
               5'($urandom_range(31, 0)));
      step(i == 3 ? "freeze_release" : "freeze_hold");
    end

    // self-dependent load alternates stall / load: counter saturation
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h200, 32'h1, 32'h2, 32'h3, 5, 5, 5);
    for (int i = 0; i < 40; i++) step("sat");
    chk("sat/cnt_lit", 160'(ifa.stall_cnt), 160'(4'hF));

    // asynchronous reset mid-cycle with a load in EX
    idv = mk(1, 4'b0000, 1, 0, 1, 1, 2'b00, 32'h300, 32'h4, 32'h5, 32'h6, 1, 2, 5);
    step("ld_before_rst");
    chk("pre_rst/valid_lit", 160'(ifa.ex_valid), 160'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst/ex_f", 160'(obs_f()), 160'(0));
    chk("async_rst/ex_n", 160'(obs_n()), 160'(0));
    chk("async_rst/cnt_f", 160'(ifa.stall_cnt), 160'(0));
    chk("async_rst/cnt_n", 160'(ifb.stall_cnt), 160'(0));
    chk("async_rst/hz_f", 160'(ifa.hazard_stall), 160'(0));
    chk("async_rst/hz_n", 160'(ifb.hazard_stall), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline boundary, directly downstream of the opcode decoder.
- Registers decoded control (alu command, mem_read/mem_write, wb_enable, is_immediate, branch_type) plus operands and register indices into the EX stage.
- Detects read-after-write hazards against EX and MEM and raises hazard_stall, which holds PC and IF/ID while a bubble enters EX.
- Handles branch flush and memory-wait freeze, and counts stall cycles.

Parameters:
- FORWARD_EN, 1: 1 = forwarding unit present, so only load-use in EX stalls. 0 = any pending write in EX or MEM to a used source stalls.
- DATA_W, 32: width of PC, operand and immediate fields.
- REG_AW, 5: register index width. Register 0 is hardwired zero and never causes a hazard.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  memory wait; hold all state
- flush  in  1  branch taken in EX; squash ID instruction
- id_valid  in  1  ID holds a real instruction
- id_alu_cmd  in  4  decoded ALU command
- id_mem_read  in  1  decoded load
- id_mem_write  in  1  decoded store
- id_wb_en  in  1  decoded register write-back
- id_is_imm  in  1  decoded immediate operand select
- id_branch_type  in  2  decoded branch type
- id_pc  in  DATA_W  PC+4 of ID instruction
- id_val1  in  DATA_W  register-file read 1
- id_val2  in  DATA_W  register-file read 2
- id_imm  in  DATA_W  sign-extended immediate
- id_src1  in  REG_AW  source index 1
- id_src2  in  REG_AW  source index 2
- id_dest  in  REG_AW  destination index
- mem_wb_en  in  1  MEM-stage instruction writes back
- mem_dest  in  REG_AW  MEM-stage destination
- ex_valid  out  1  EX holds a real instruction
- ex_alu_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm, ex_branch_type  out  4/1/1/1/1/2  registered control
- ex_pc, ex_val1, ex_val2, ex_imm  out  DATA_W  registered data
- ex_src1, ex_src2, ex_dest  out  REG_AW  registered indices
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst=1): every ex_* output = 0, ex_valid = 0, stall_cnt = 0. hazard_stall evaluates to 0 because ex_* is zero and mem_wb_en is assumed 0 during reset.
- Latency: one cycle. On the edge, ID inputs appear on ex_* when no stall, flush or freeze is active.
- Source use:
  - src1_used = id_valid.
  - src2_used = id_valid & !id_is_imm & !id_mem_read & (id_branch_type != 2'b01).
  - Jump false-stalls on src2. This is conservative and accepted.
- Match rule: match(s, d) = (s == d) & (d != 0).
- FORWARD_EN=1: hazard_stall = ex_valid & ex_mem_read & ex_wb_en & (src1_used & match(id_src1, ex_dest) | src2_used & match(id_src2, ex_dest)).
- FORWARD_EN=0: hazard_stall = (ex_valid & ex_wb_en & any used-source match on ex_dest) | (mem_wb_en & any used-source match on mem_dest).
- Clock-edge update priority, highest first:
  1. freeze: all registers hold, stall_cnt holds.
  2. flush: load bubble (all ex_* = 0, ex_valid = 0). A simultaneous hazard_stall is ignored for the bubble, but stall_cnt still counts it.
  3. hazard_stall: load bubble.
  4. Otherwise: load all id_* fields, with ex_valid = id_valid.
- Bubble: every control bit, index and data field is zero. It never writes memory or registers.
- hazard_stall is produced even while freeze=1. Upstream gates its own hold with freeze.
- stall_cnt increments by 1 on every non-freeze edge with hazard_stall=1, and saturates at all-ones.
- id_valid=0 never causes a stall.

Decomposition:
- Shared package cpu_pkg:
  - ALU command codes, e.g. ALU_ADD=4'b0000, ALU_SUB=4'b0010.
  - Branch type codes BR_BEZ=2'b01, BR_BNE=2'b10, BR_JMP=2'b00.
  - Widths DATA_W and REG_AW.
  - Bubble constant for the control bundle.
- Sub-module hazard_detect: purely combinational; owns the src-use decode and the FORWARD_EN selection.
- id_ex_stage_reg instantiates hazard_detect plus the register bank and stall counter.

Test Plan:
- Reset: assert rst mid-cycle with EX holding a load (ex_valid=1) -> all ex_* = 0 and stall_cnt = 0 asynchronously, hazard_stall = 0.
- Load-use, FORWARD_EN=1: EX has a load with ex_dest=5; ID has an add with src1=5 -> hazard_stall=1 for one cycle, bubble enters EX, stall_cnt=1. Next cycle the add enters EX with val/imm fields intact.
- R0 and immediate: EX has a load with dest=0 and ID uses src1=0 -> no stall. EX has a load with dest=7 and ID is an addi with src2=7 -> no stall.
- FORWARD_EN=0 MEM hazard: mem_wb_en=1, mem_dest=3, ID has a store with src2=3 -> hazard_stall=1. Once mem_wb_en drops, the instruction is loaded normally.
- Flush vs stall: flush=1 and hazard_stall=1 on the same edge -> EX = bubble and stall_cnt increments. flush=1 with freeze=1 -> EX unchanged.
- Freeze: freeze=1 for 3 cycles with new ID values each cycle -> ex_* constant and stall_cnt constant. On release, the current ID values are captured.
- Counter saturation (CNT_W=4): stall 20 cycles -> stall_cnt = 15.
